// File: rtl/regfile_2w2r.sv
// 2^AW x DW register file: two combinational read ports, two write ports (port 1 wins), r0 hardwired to 0.
// clr starts an init sweep writing idx to regs 1..INIT_N-1 and 0 elsewhere; busy is high for the sweep.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_2w2r #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int INIT_N = 5
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    output logic [DW-1:0] qa,
    output logic [DW-1:0] qb,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] wn0,
    input  logic [AW-1:0] wn1,
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    output logic          busy
);

    localparam int            NREG = 1 << AW;
    localparam logic [AW-1:0] LAST = {AW{1'b1}};

    typedef enum logic {READY, INIT} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          busy_nxt;
    logic [DW-1:0] init_val;
    logic [DW-1:0] regs [NREG];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == INIT) begin
            // cnt parks at LAST instead of wrapping back onto register 0
            if (cnt == LAST) begin
                state_nxt = READY;
            end else begin
                cnt_nxt = cnt + AW'(1);
            end
        end
        busy_nxt = (state_nxt == INIT);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= INIT;
            cnt   <= AW'(1);
            busy  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_nxt;
        end
    end

    assign init_val = (int'(cnt) < INIT_N) ? DW'(cnt) : '0;

    // Array has no reset: contents are defined only by the sweep.
    always_ff @(posedge clk) begin
        if (!clr) begin
            if (busy) begin
                regs[cnt] <= init_val;
            end else begin
                if (we0 && (wn0 != '0)) regs[wn0] <= d0;
                if (we1 && (wn1 != '0)) regs[wn1] <= d1;
            end
        end
    end

    function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = (a == '0) ? '0 : regs[a];
`ifdef REGFILE_BYPASS_EN
        if (!busy && !clr && (a != '0)) begin
            if (we1 && (wn1 == a))      v = d1;
            else if (we0 && (wn0 == a)) v = d0;
        end
`endif
        return v;
    endfunction

    always_comb begin
        qa = rd(ra);
        qb = rd(rb);
    end

endmodule

// File: tb/tb_regfile_2w2r.sv
// Randomised bench for regfile_2w2r against an array-based reference model.
module tb_regfile_2w2r;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic [AW-1:0] ra = '0, rb = '0, wn0 = '0, wn1 = '0;
    logic [DW-1:0] qa, qb, d0 = '0, d1 = '0;
    logic          we0 = 1'b0, we1 = 1'b0;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] model [N];
    bit            known [N];
    bit            m_busy = 1'b0;
    int            m_pos  = 1;

    regfile_2w2r #(.DW(DW), .AW(AW), .INIT_N(5)) dut (
        .clk(clk), .clr(clr), .ra(ra), .rb(rb), .qa(qa), .qb(qb),
        .we0(we0), .we1(we1), .wn0(wn0), .wn1(wn1), .d0(d0), .d1(d1),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one rising edge, using the inputs as driven.
    task automatic model_edge();
        if (clr) begin
            m_busy = 1'b1;
            m_pos  = 1;
        end else if (m_busy) begin
            model[m_pos] = (m_pos < 5) ? DW'(m_pos) : '0;
            known[m_pos] = 1'b1;
            if (m_pos == N - 1) m_busy = 1'b0;
            else                m_pos++;
        end else begin
            if (we0 && wn0 != 0) begin model[wn0] = d0; known[wn0] = 1'b1; end
            if (we1 && wn1 != 0) begin model[wn1] = d1; known[wn1] = 1'b1; end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic exp_rd(input logic [AW-1:0] a, output logic [DW-1:0] v, output bit ok);
        ok = 1'b1;
        if (a == 0) begin v = '0; return; end
        v  = model[a];
        ok = known[a];
`ifdef REGFILE_BYPASS_EN
        if (!m_busy && !clr) begin
            if (we1 && wn1 == a)      begin v = d1; ok = 1'b1; end
            else if (we0 && wn0 == a) begin v = d0; ok = 1'b1; end
        end
`endif
    endtask

    task automatic check_outputs(input string tag);
        logic [DW-1:0] v;
        bit ok;
        #1;
        exp_rd(ra, v, ok);
        if (ok) chk({tag, "_qa"}, qa, v);
        exp_rd(rb, v, ok);
        if (ok) chk({tag, "_qb"}, qb, v);
        chk({tag, "_busy"}, DW'(busy), DW'(m_busy));
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; clr = 1'b0;
    endtask

    task automatic read_reg(input int i, input logic [DW-1:0] exp, input string tag);
        ra = AW'(i);
        rb = AW'(N - 1 - i);
        #1;
        chk(tag, qa, exp);
    endtask

    task automatic wait_sweep(input string tag);
        int cycles = 0;
        while (busy && cycles < 100) begin
            tick();
            cycles++;
        end
        chk(tag, DW'(cycles), DW'(31));
    endtask

    initial begin
        logic [DW-1:0] old6;
        for (int i = 0; i < N; i++) begin model[i] = '0; known[i] = 1'b0; end
        @(negedge clk);

        // One-cycle clr, then an idle sweep.
        idle(); clr = 1'b1;
        tick();
        clr = 1'b0;
        #1 chk("busy_after_clr", DW'(busy), 32'd1);
        wait_sweep("sweep_len");
        chk("busy_done", DW'(busy), 32'd0);
        for (int i = 0; i < N; i++)
            read_reg(i, (i >= 1 && i <= 4) ? DW'(i) : '0, $sformatf("init_r%0d", i));

        // Two writes in one cycle to different addresses.
        we0 = 1'b1; wn0 = 7; d0 = 32'hA5A5A5A5;
        we1 = 1'b1; wn1 = 9; d1 = 32'h12345678;
        tick(); idle();
        read_reg(7, 32'hA5A5A5A5, "dual_r7");
        read_reg(9, 32'h12345678, "dual_r9");

        // Same-address collision and write to r0.
        we0 = 1'b1; wn0 = 3; d0 = 32'h11;
        we1 = 1'b1; wn1 = 3; d1 = 32'h22;
        tick(); idle();
        read_reg(3, 32'h22, "collide_r3");
        we0 = 1'b1; wn0 = 0; d0 = 32'hFFFFFFFF;
        tick(); idle();
        read_reg(0, 32'h0, "r0_write");

        // Bypass / read-before-write on r6.
        we0 = 1'b1; wn0 = 6; d0 = 32'h600D;
        tick(); idle();
        old6 = 32'h600D;
        ra = 6; we1 = 1'b1; wn1 = 6; d1 = 32'hDEAD;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_same_cycle", qa, 32'hDEAD);
`else
        chk("no_bypass_old", qa, old6);
`endif
        tick(); idle();
        #1 chk("r6_after_edge", qa, 32'hDEAD);

        // clr mid-sweep with we0 active; write must be ignored.
        clr = 1'b1; tick(); clr = 1'b0;
        we0 = 1'b1; wn0 = 2; d0 = 32'hBAD0BAD0;
        for (int i = 0; i < 10; i++) tick();
        clr = 1'b1; tick(); clr = 1'b0;
        #1 chk("restart_busy", DW'(busy), 32'd1);
        wait_sweep("restart_len");
        idle();
        read_reg(2, 32'd2, "restart_r2");
        read_reg(7, 32'd0, "restart_r7");

        // Random traffic with occasional clr pulses.
        for (int c = 0; c < 2000; c++) begin
            clr = ($urandom_range(0, 199) == 0);
            we0 = $urandom_range(0, 1); we1 = $urandom_range(0, 1);
            wn0 = AW'($urandom); wn1 = ($urandom_range(0, 3) == 0) ? wn0 : AW'($urandom);
            d0  = $urandom; d1 = $urandom;
            ra  = AW'($urandom); rb = ($urandom_range(0, 3) == 0) ? wn1 : AW'($urandom);
            check_outputs("rand");
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
